// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the four-port calculator
package calc_pkg;

    localparam int DW  = 32;
    localparam int LAT = 3;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        SHL = 4'd5,
        SHR = 4'd6
    } cmd_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        OK   = 2'd1,
        ERR  = 2'd2,
        RSVD = 2'd3
    } resp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } port_state_t;

endpackage

// File: rtl/calc_port.sv
// rtl/calc_port.sv - one requester port: request FSM, operand regs, ALU, result pipeline
module calc_port
    import calc_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [3:0]    cmd_i,
    input  logic [DW-1:0] data_i,
    output logic [1:0]    resp_o,
    output logic [DW-1:0] data_o
);

    port_state_t   state_q, state_d;
    logic [3:0]    cmd_q;
    logic [DW-1:0] op1_q;
    logic [DW-1:0] op2_q;
    logic          fire_q;
    resp_t         alu_resp;
    logic [DW-1:0] alu_data;
    logic [DW:0]   sum;
    logic [DW+1:0] pipe_q [LAT];

    logic accept;
    assign accept = (state_q == ST_IDLE) && (cmd_i != NOP);

    // Request FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a non-zero command opens a request, operand2 always closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_i != NOP) state_d = ST_OP2;
            ST_OP2:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture; fire_q marks the cycle in which the ALU inputs are complete.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            fire_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q <= cmd_i;
                op1_q <= data_i;
            end
            if (state_q == ST_OP2) begin
                op2_q <= data_i;
            end
            fire_q <= (state_q == ST_OP2);
        end
    end

    assign sum = {1'b0, op1_q} + {1'b0, op2_q};

    // ALU: error results always carry zero data; shifts use only the 5 LSBs of operand2.
    always_comb begin
        alu_resp = ERR;
        alu_data = '0;
        case (cmd_q)
            ADD: begin
                if (!sum[DW]) begin
                    alu_resp = OK;
                    alu_data = sum[DW-1:0];
                end
            end
            SUB: begin
                if (op2_q <= op1_q) begin
                    alu_resp = OK;
                    alu_data = op1_q - op2_q;
                end
            end
            SHL: begin
                alu_resp = OK;
                alu_data = op1_q << op2_q[4:0];
            end
            SHR: begin
                alu_resp = OK;
                alu_data = op1_q >> op2_q[4:0];
            end
            default: begin
                alu_resp = ERR;
                alu_data = '0;
            end
        endcase
    end

    // Result shift register; empty slots carry {NONE, 0} so the outputs idle at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= fire_q ? {alu_resp, alu_data} : '0;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign resp_o = pipe_q[LAT-1][DW+1:DW];
    assign data_o = pipe_q[LAT-1][DW-1:0];

endmodule

// File: rtl/calc_1.sv
// rtl/calc_1.sv - four independent calculator ports
module calc_1
    import calc_pkg::*;
(
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    output logic [0:1]  out_resp1,
    output logic [0:31] out_data1,
    output logic [0:1]  out_resp2,
    output logic [0:31] out_data2,
    output logic [0:1]  out_resp3,
    output logic [0:31] out_data3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data4
);

    calc_port u_port1 (
        .clk_i  (c_clk),
        .rst_ni (reset),
        .cmd_i  (req1_cmd_in),
        .data_i (req1_data_in),
        .resp_o (out_resp1),
        .data_o (out_data1)
    );

    calc_port u_port2 (
        .clk_i  (c_clk),
        .rst_ni (reset),
        .cmd_i  (req2_cmd_in),
        .data_i (req2_data_in),
        .resp_o (out_resp2),
        .data_o (out_data2)
    );

    calc_port u_port3 (
        .clk_i  (c_clk),
        .rst_ni (reset),
        .cmd_i  (req3_cmd_in),
        .data_i (req3_data_in),
        .resp_o (out_resp3),
        .data_o (out_data3)
    );

    calc_port u_port4 (
        .clk_i  (c_clk),
        .rst_ni (reset),
        .cmd_i  (req4_cmd_in),
        .data_i (req4_data_in),
        .resp_o (out_resp4),
        .data_o (out_data4)
    );

endmodule

// File: tb/tb_calc_1.sv
// tb/tb_calc_1.sv - scoreboard bench for calc_1 with a behavioural reference model
module tb_calc_1;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cmd  [4];
    logic [31:0] din  [4];
    logic [1:0]  resp [4];
    logic [31:0] dout [4];

    always #5 c_clk = ~c_clk;

    calc_1 dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd[0]),
        .req1_data_in (din[0]),
        .req2_cmd_in  (cmd[1]),
        .req2_data_in (din[1]),
        .req3_cmd_in  (cmd[2]),
        .req3_data_in (din[2]),
        .req4_cmd_in  (cmd[3]),
        .req4_data_in (din[3]),
        .out_resp1    (resp[0]),
        .out_data1    (dout[0]),
        .out_resp2    (resp[1]),
        .out_data2    (dout[1]),
        .out_resp3    (resp[2]),
        .out_data3    (dout[2]),
        .out_resp4    (resp[3]),
        .out_data4    (dout[3])
    );

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb [4][$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge c_clk) cyc++;

    task automatic check(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s port%0d: got %0h expected %0h (cycle %0d)", nm, p + 1, act, exp, cyc);
        end
    endtask

    // Reference: add/sub checked against the 32-bit unsigned range, shifts modulo 32.
    function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        wide = 64'(a) + 64'(b);
        case (c)
            4'd1:    return (wide > 64'hFFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, wide[31:0]};
            4'd2:    return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5:    return {2'd1, a << (b % 32)};
            4'd6:    return {2'd1, a >> (b % 32)};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    task automatic send(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] er, input logic [31:0] ed);
        exp_t e;
        cmd[p] = c;
        din[p] = a;
        e.resp = er;
        e.data = ed;
        e.at   = cyc + 5;
        sb[p].push_back(e);
        @(posedge c_clk); #1;
        cmd[p] = 4'($urandom);
        din[p] = b;
        @(posedge c_clk); #1;
        cmd[p] = 4'd0;
        din[p] = $urandom;
    endtask

    task automatic send_m(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [33:0] r;
        r = model(c, a, b);
        send(p, c, a, b, r[33:32], r[31:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge c_clk); #1;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 40));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
            default: return 32'h8000_0000;
        endcase
    endfunction

    task automatic rand_port(input int p, input int n);
        logic [3:0] c;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
                0:       c = 4'd1;
                1:       c = 4'd2;
                2:       c = 4'd5;
                3:       c = 4'd6;
                default: c = 4'($urandom_range(1, 15));
            endcase
            send_m(p, c, pick_operand(), pick_operand());
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 40) begin
            @(posedge c_clk); #1;
            n++;
        end
    endtask

    // Monitor: every non-zero response must match the oldest expectation of its port.
    exp_t got;
    always @(negedge c_clk) begin
        for (int p = 0; p < 4; p++) begin
            if (resp[p] != 2'd0) begin
                if (sb[p].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected port%0d: got resp=%0d data=%0h expected no response", p + 1, resp[p], dout[p]);
                end else begin
                    got = sb[p].pop_front();
                    check("resp", p, 32'(resp[p]), 32'(got.resp));
                    check("data", p, dout[p], got.data);
                    check("latency", p, 32'(cyc), 32'(got.at));
                end
            end else begin
                check("idle_data", p, dout[p], 32'd0);
            end
        end
    end

    initial begin
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0;
            din[p] = 32'd0;
        end
        reset = 1'b0;
        idle(2);
        for (int p = 0; p < 4; p++) begin
            check("reset_resp", p, 32'(resp[p]), 32'd0);
            check("reset_data", p, dout[p], 32'd0);
        end
        reset = 1'b1;

        send(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000);
        send(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);
        send(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
        send(0, 4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0);
        send(0, 4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E);
        send(0, 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0);
        send(0, 4'd5, 32'h0000_0001, 32'h0000_0024, 2'd1, 32'h0000_0010);
        send(0, 4'd6, 32'h8000_0000, 32'd31,        2'd1, 32'h0000_0001);
        send(0, 4'd3, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0);
        send(0, 4'd4, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0);
        send(0, 4'd15, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0);
        drain();

        fork
            send(0, 4'd1, 32'd10,   32'd1, 2'd1, 32'd11);
            send(1, 4'd1, 32'd200,  32'd2, 2'd1, 32'd202);
            send(2, 4'd1, 32'd3000, 32'd3, 2'd1, 32'd3003);
            send(3, 4'd1, 32'hFFFF_FFFE, 32'd2, 2'd2, 32'd0);
        join
        drain();

        for (int i = 0; i < 10; i++) begin
            send_m(0, 4'd1, $urandom_range(0, 32'h7FFF_FFFF), $urandom_range(0, 32'h7FFF_FFFF));
        end
        drain();

        fork
            rand_port(0, 30);
            rand_port(1, 30);
            rand_port(2, 30);
            rand_port(3, 30);
        join
        drain();

        send_m(1, 4'd1, 32'd5, 32'd6);
        idle(2);
        cmd[0] = 4'd1;
        din[0] = 32'd7;
        @(posedge c_clk); #1;
        check("pre_reset_resp", 1, 32'(resp[1]), 32'd1);
        cmd[0] = 4'd0;
        din[0] = 32'd8;
        #1;
        reset = 1'b0;
        for (int p = 0; p < 4; p++) sb[p].delete();
        #1;
        for (int p = 0; p < 4; p++) begin
            check("async_reset_resp", p, 32'(resp[p]), 32'd0);
            check("async_reset_data", p, dout[p], 32'd0);
        end
        idle(3);
        reset = 1'b1;
        idle(10);
        send(0, 4'd1, 32'd100, 32'd23, 2'd1, 32'd123);
        drain();

        for (int p = 0; p < 4; p++) begin
            check("drained", p, 32'(sb[p].size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
